// File: rtl/branch_resolve_unit_if.sv
// Handshake bundle for the branch resolve unit.
// Upstream ALU side and downstream fetch side.
interface branch_resolve_unit_if #(
  parameter int DW = 64
);
  logic          i_valid;
  logic          o_ready;
  logic [1:0]    i_kind;
  logic          i_flag_we;
  logic          i_alu_z;
  logic          i_alu_n;
  logic [3:0]    i_cond;
  logic [DW-1:0] i_pc;
  logic [DW-1:0] i_offset;
  logic          o_valid;
  logic          i_ready;
  logic          o_taken;
  logic [DW-1:0] o_target;
  logic          o_illegal;
  logic [1:0]    o_flags;

  modport master (
    output i_valid, i_kind, i_flag_we,
    output i_alu_z, i_alu_n, i_cond,
    output i_pc, i_offset, i_ready,
    input  o_ready, o_valid, o_taken,
    input  o_target, o_illegal, o_flags
  );

  modport slave (
    input  i_valid, i_kind, i_flag_we,
    input  i_alu_z, i_alu_n, i_cond,
    input  i_pc, i_offset, i_ready,
    output o_ready, o_valid, o_taken,
    output o_target, o_illegal, o_flags
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: N/Z flag register, CBZ/CBNZ/B.cond
// evaluation, output register plus one skid entry.
module branch_resolve_unit #(
  parameter int DW = 64
) (
  input logic              i_clk,
  input logic              i_rst,
  branch_resolve_unit_if.slave bus
);

  typedef struct packed {
    logic          taken;
    logic          illegal;
    logic [DW-1:0] target;
  } res_t;

  logic       rdy_q, rdy_d;
  logic [1:0] flags_q, flags_d;
  logic       out_vld_q, out_vld_d;
  res_t       out_q, out_d;
  logic       skid_vld_q, skid_vld_d;
  res_t       skid_q, skid_d;

  logic       accept, deliver;
  logic       cond_ok, cond_hit;
  logic       bad;
  logic       take;
  res_t       res;

  assign accept  = bus.i_valid & rdy_q;
  assign deliver = out_vld_q & bus.i_ready;

  // decode the B.cond field against the flag register {N,Z}
  always_comb begin
    cond_ok  = 1'b1;
    cond_hit = 1'b0;
    case (bus.i_cond)
      4'b0000: cond_hit = flags_q[0];
      4'b0001: cond_hit = ~flags_q[0];
      4'b0100: cond_hit = flags_q[1];
      4'b0101: cond_hit = ~flags_q[1];
      4'b1011: cond_hit = flags_q[1];
      4'b1010: cond_hit = ~flags_q[1];
      4'b1110: cond_hit = 1'b1;
      default: cond_ok  = 1'b0;
    endcase
  end

  // resolve taken/target/illegal for the incoming transaction
  always_comb begin
    bad  = 1'b0;
    take = 1'b0;
    case (bus.i_kind)
      2'b01:   take = bus.i_alu_z;
      2'b10:   take = ~bus.i_alu_z;
      2'b11: begin
        bad  = bus.i_flag_we | ~cond_ok;
        take = ~bad & cond_hit;
      end
      default: take = 1'b0;
    endcase
    res.taken   = take;
    res.illegal = bad;
    res.target  = take ? bus.i_pc + (bus.i_offset << 2)
                       : bus.i_pc + DW'(4);
  end

  // next state of flags, output register and skid entry
  always_comb begin
    flags_d    = flags_q;
    out_vld_d  = out_vld_q;
    out_d      = out_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    if (accept && bus.i_flag_we && bus.i_kind != 2'b11)
      flags_d = {bus.i_alu_n, bus.i_alu_z};
    if (skid_vld_q) begin
      if (deliver) begin
        out_d      = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (!out_vld_q || deliver) begin
      out_vld_d = accept;
      if (accept)
        out_d = res;
    end else if (accept) begin
      skid_vld_d = 1'b1;
      skid_d     = res;
    end
    rdy_d = ~skid_vld_d;
  end

  // state registers, synchronous reset discards everything
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rdy_q      <= 1'b1;
      flags_q    <= 2'b00;
      out_vld_q  <= 1'b0;
      out_q      <= '0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
    end else begin
      rdy_q      <= rdy_d;
      flags_q    <= flags_d;
      out_vld_q  <= out_vld_d;
      out_q      <= out_d;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
    end
  end

  assign bus.o_ready   = rdy_q;
  assign bus.o_valid   = out_vld_q;
  assign bus.o_taken   = out_q.taken;
  assign bus.o_illegal = out_q.illegal;
  assign bus.o_target  = out_q.target;
  assign bus.o_flags   = flags_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit.
// Scoreboard of expected results, checked on delivery.
module tb_branch_resolve_unit;

  localparam int DW = 64;

  typedef struct packed {
    logic          taken;
    logic          illegal;
    logic [DW-1:0] target;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run  = 0;
  int   n_fail = 0;
  int   n_dlv  = 0;
  logic [1:0] mflags = 2'b00;
  exp_t sb[$];

  branch_resolve_unit_if #(.DW(DW)) bus ();

  branch_resolve_unit #(.DW(DW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic cond_true(input logic [3:0] c,
                                     input logic [1:0] f,
                                     output logic ok);
    ok = 1'b1;
    cond_true = 1'b0;
    if (c == 4'b0000) cond_true = f[0];
    else if (c == 4'b0001) cond_true = !f[0];
    else if (c == 4'b0100) cond_true = f[1];
    else if (c == 4'b0101) cond_true = !f[1];
    else if (c == 4'b1011) cond_true = f[1];
    else if (c == 4'b1010) cond_true = !f[1];
    else if (c == 4'b1110) cond_true = 1'b1;
    else ok = 1'b0;
  endfunction

  function automatic exp_t model();
    exp_t e;
    logic ok, hit;
    hit = cond_true(bus.i_cond, mflags, ok);
    e.illegal = (bus.i_kind == 2'b11) &&
                (bus.i_flag_we || !ok);
    case (bus.i_kind)
      2'b01:   e.taken = bus.i_alu_z;
      2'b10:   e.taken = !bus.i_alu_z;
      2'b11:   e.taken = !e.illegal && hit;
      default: e.taken = 1'b0;
    endcase
    if (e.taken)
      e.target = bus.i_pc + {bus.i_offset[DW-3:0], 2'b00};
    else
      e.target = bus.i_pc + 64'd4;
    return e;
  endfunction

  // one cycle; record the transaction if it will be accepted
  task automatic step();
    if (!rst && bus.i_valid && bus.o_ready) begin
      sb.push_back(model());
      if (bus.i_flag_we && bus.i_kind != 2'b11)
        mflags = {bus.i_alu_n, bus.i_alu_z};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic [1:0] k, input logic fwe,
                     input logic z, input logic n,
                     input logic [3:0] c,
                     input logic [63:0] pc,
                     input logic [63:0] off);
    bus.i_kind    = k;
    bus.i_flag_we = fwe;
    bus.i_alu_z   = z;
    bus.i_alu_n   = n;
    bus.i_cond    = c;
    bus.i_pc      = pc;
    bus.i_offset  = off;
  endtask

  task automatic send();
    logic acc;
    bus.i_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = bus.o_ready;
      step();
    end
    bus.i_valid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++)
      step();
    chk("drain_empty", 64'(sb.size()), 0);
  endtask

  // compare every delivery against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.o_valid && bus.i_ready) begin
      n_dlv++;
      if (sb.size() == 0) begin
        chk("unexpected_dlv", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("dlv_taken", 64'(bus.o_taken), 64'(e.taken));
        chk("dlv_target", bus.o_target, e.target);
        chk("dlv_illegal", 64'(bus.o_illegal),
            64'(e.illegal));
      end
    end
  end

  initial begin
    int d0;
    logic [63:0] hold;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    set(2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 64'h0, 64'h0);
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("rst_valid", 64'(bus.o_valid), 0);
    chk("rst_taken", 64'(bus.o_taken), 0);
    chk("rst_target", bus.o_target, 0);
    chk("rst_illegal", 64'(bus.o_illegal), 0);
    chk("rst_flags", 64'(bus.o_flags), 0);
    chk("rst_ready", 64'(bus.o_ready), 1);

    // ADDS z=1 n=0
    set(2'b00, 1'b1, 1'b1, 1'b0, 4'h0, 64'h1000, 64'h0);
    send();
    chk("adds_flags", 64'(bus.o_flags), 64'h1);
    chk("adds_target", bus.o_target, 64'h1004);
    chk("adds_taken", 64'(bus.o_taken), 0);

    // SUBS then B.cond LT back to back
    set(2'b00, 1'b1, 1'b0, 1'b1, 4'h0, 64'h50, 64'h0);
    bus.i_valid = 1'b1;
    step();
    set(2'b11, 1'b0, 1'b0, 1'b0, 4'b1011, 64'h100,
        -64'sd4);
    step();
    bus.i_valid = 1'b0;
    chk("lt_taken", 64'(bus.o_taken), 1);
    chk("lt_target", bus.o_target, 64'hF0);
    chk("subs_flags", 64'(bus.o_flags), 64'h2);

    // CBZ / CBNZ
    set(2'b01, 1'b0, 1'b1, 1'b0, 4'h0, 64'h200, 64'h3);
    send();
    chk("cbz_target", bus.o_target, 64'h20C);
    set(2'b10, 1'b0, 1'b1, 1'b0, 4'h0, 64'h200, 64'h3);
    send();
    chk("cbnz_target", bus.o_target, 64'h204);
    chk("cbnz_taken", 64'(bus.o_taken), 0);

    // every cond code under random flags
    for (int c = 0; c < 16; c++) begin
      set(2'b00, 1'b1, 1'($urandom_range(1)),
          1'($urandom_range(1)), 4'h0, 64'h0, 64'h0);
      send();
      set(2'b11, 1'b0, 1'b0, 1'b0, 4'(c),
          64'($urandom), 64'($urandom_range(255)));
      send();
    end

    // wrap-around of pc+4 and of the shifted offset
    set(2'b00, 1'b0, 1'b0, 1'b0, 4'h0, '1 - 64'd3, 64'h0);
    send();
    set(2'b01, 1'b0, 1'b1, 1'b0, 4'h0, 64'h0,
        64'hC000_0000_0000_0001);
    send();
    drain();
    chk("wrap_target", bus.o_target, 64'h4);

    // stall: two accepted, third held off
    d0 = n_dlv;
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1;
    set(2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 64'h300, 64'h0);
    step();
    set(2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 64'h400, 64'h0);
    step();
    chk("stall_ready", 64'(bus.o_ready), 0);
    hold = bus.o_target;
    chk("stall_first", hold, 64'h304);
    set(2'b01, 1'b0, 1'b1, 1'b0, 4'h0, 64'h500, 64'h1);
    step();
    step();
    chk("stall_hold", bus.o_target, hold);
    chk("stall_vld", 64'(bus.o_valid), 1);
    chk("stall_ready2", 64'(bus.o_ready), 0);
    bus.i_ready = 1'b1;
    send();
    drain();
    chk("stall_count", 64'(n_dlv - d0), 3);

    // illegal cond and illegal flag update
    set(2'b11, 1'b0, 1'b0, 1'b0, 4'b0010, 64'h600, 64'h8);
    send();
    chk("cs_illegal", 64'(bus.o_illegal), 1);
    chk("cs_taken", 64'(bus.o_taken), 0);
    hold = 64'(bus.o_flags);
    set(2'b11, 1'b1, ~bus.o_flags[0], ~bus.o_flags[1],
        4'b1110, 64'h700, 64'h8);
    send();
    chk("bad_we_flags", 64'(bus.o_flags), 64'(mflags));
    chk("bad_we_hold", 64'(bus.o_flags), hold);
    chk("bad_we_illegal", 64'(bus.o_illegal), 1);
    drain();

    // reset with skid full
    bus.i_ready = 1'b0;
    set(2'b00, 1'b1, 1'b1, 1'b1, 4'h0, 64'h800, 64'h0);
    bus.i_valid = 1'b1;
    step();
    step();
    bus.i_valid = 1'b0;
    step();
    chk("pre_rst_ready", 64'(bus.o_ready), 0);
    rst = 1'b1;
    sb.delete();
    mflags = 2'b00;
    step();
    rst = 1'b0;
    bus.i_ready = 1'b1;
    chk("rst2_valid", 64'(bus.o_valid), 0);
    chk("rst2_flags", 64'(bus.o_flags), 0);
    chk("rst2_ready", 64'(bus.o_ready), 1);
    set(2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 64'h900, 64'h0);
    send();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
